dual_port_byte_ram: RTL and testbench

- True dual-port, byte-write-enabled synchronous RAM with 32-bit words and 2**SCALE bytes of storage.
- Both ports share one clock and are symmetric.
- Serves as the data body of the data cache:
  - port 0 handles processor accesses;
  - port 1 handles refill writes from DRAM.
- Reads are registered, with one-cycle latency.

---
 rtl/dual_port_byte_ram_if.sv | 42 ++++
 rtl/dual_port_byte_ram.sv | 81 ++++++++
 tb/tb_dual_port_byte_ram.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/dual_port_byte_ram_if.sv
`default_nettype none
// ============================================================================
//  Module      : dual_port_byte_ram_if
//  Description : Bus bundle for the two symmetric ports of dual_port_byte_ram.
//                The master drives enables, addresses and write data.
//                The slave (the RAM) returns registered read data.
//  Revision    : 1.0  initial release
// ============================================================================
interface dual_port_byte_ram_if #(
    parameter int SCALE = 10
);

    // Port 0: processor side
    logic               oe0;
    logic [SCALE-1:0]   addr0;
    logic [31:0]        wdata0;
    logic [3:0]         we0;
    logic [31:0]        rdata0;

    // Port 1: refill side
    logic               oe1;
    logic [SCALE-1:0]   addr1;
    logic [31:0]        wdata1;
    logic [3:0]         we1;
    logic [31:0]        rdata1;

    modport master (
        output oe0, addr0, wdata0, we0,
        input  rdata0,
        output oe1, addr1, wdata1, we1,
        input  rdata1
    );

    modport slave (
        input  oe0, addr0, wdata0, we0,
        output rdata0,
        input  oe1, addr1, wdata1, we1,
        output rdata1
    );

endinterface : dual_port_byte_ram_if
`default_nettype wire

// File: rtl/dual_port_byte_ram.sv
`default_nettype none
// ============================================================================
//  Module      : dual_port_byte_ram
//  Description : True dual-port synchronous RAM with 32-bit words and
//                per-byte write enables. Reads are registered and read-first.
//                On a same-byte write collision, port 1 wins.
//                The reset clears only the read registers, never the storage.
//  Revision    : 1.0  initial release
// ============================================================================
module dual_port_byte_ram #(
    parameter int SCALE = 10
) (
    input  wire logic             clk,
    input  wire logic             rst,      // asynchronous, active low
    dual_port_byte_ram_if.slave   bus
);

    localparam int c_IDX_W = SCALE - 2;
    localparam int c_WORDS = 1 << c_IDX_W;
    localparam int c_LANES = 4;

    // Storage starts zeroed at time 0 and is never touched by the reset.
    logic [31:0] mem_q [c_WORDS] = '{default: '0};

    logic [31:0] rdata0_q;
    logic [31:0] rdata0_d;
    logic [31:0] rdata1_q;
    logic [31:0] rdata1_d;

    // Word indices: the low two address bits select a byte within a word,
    // and the byte lanes are fixed, so those bits are not used.
    wire logic [c_IDX_W-1:0] w_idx0 = bus.addr0[SCALE-1:2];
    wire logic [c_IDX_W-1:0] w_idx1 = bus.addr1[SCALE-1:2];
    wire logic               w_unused_lowbits = ^{bus.addr0[1:0], bus.addr1[1:0]};

    // Byte-lane writes for both ports.
    // Port 1 is applied last, so it wins on a same-byte collision.
    // The writes are qualified by rst, so an edge taken while reset is held
    // writes nothing.
    always_ff @(posedge clk or negedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_LANES; i++) begin
                if (bus.we0[i]) begin
                    mem_q[w_idx0][8*i +: 8] <= bus.wdata0[8*i +: 8];
                end
                if (bus.we1[i]) begin
                    mem_q[w_idx1][8*i +: 8] <= bus.wdata1[8*i +: 8];
                end
            end
        end
    end

    // Next read data: the current array contents (pre-write) when enabled,
    // otherwise the last value is held.
    always_comb begin
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        if (bus.oe0) begin
            rdata0_d = mem_q[w_idx0];
        end
        if (bus.oe1) begin
            rdata1_d = mem_q[w_idx1];
        end
    end

    // Registered read outputs, forced to zero immediately by the reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign bus.rdata0 = rdata0_q;
    assign bus.rdata1 = rdata1_q;

endmodule : dual_port_byte_ram
`default_nettype wire

// File: tb/tb_dual_port_byte_ram.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dual_port_byte_ram
//  Description : Directed self-checking bench for dual_port_byte_ram.
//                It checks reset and init, full-word and byte writes,
//                read-first behaviour on both ports, the write collision,
//                read-data hold, and the last word of the array.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dual_port_byte_ram;

    localparam int c_SCALE = 10;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    dual_port_byte_ram_if #(.SCALE(c_SCALE)) bus ();

    dual_port_byte_ram #(.SCALE(c_SCALE)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // 10-unit clock period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // One rising edge, then return on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.oe0    = 1'b0;
        bus.we0    = 4'b0000;
        bus.oe1    = 1'b0;
        bus.we1    = 4'b0000;
    endtask

    task automatic wr0(input logic [9:0] a, input logic [31:0] d, input logic [3:0] we);
        idle();
        bus.addr0  = a;
        bus.wdata0 = d;
        bus.we0    = we;
        tick();
        idle();
    endtask

    task automatic rd0(input logic [9:0] a);
        idle();
        bus.addr0 = a;
        bus.oe0   = 1'b1;
        tick();
        idle();
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b0;
        bus.addr0  = '0;
        bus.wdata0 = '0;
        bus.addr1  = '0;
        bus.wdata1 = '0;
        idle();

        // 1. Reset and init
        tick();
        check("reset_rdata0", bus.rdata0, 32'h0);
        check("reset_rdata1", bus.rdata1, 32'h0);
        rst = 1'b1;
        bus.addr0 = 10'h014;
        bus.addr1 = 10'h014;
        bus.oe0   = 1'b1;
        bus.oe1   = 1'b1;
        tick();
        idle();
        check("init_word5_p0", bus.rdata0, 32'h0);
        check("init_word5_p1", bus.rdata1, 32'h0);

        // 2. Full-word write, then read with the low address bits set
        wr0(10'h010, 32'hDEADBEEF, 4'b1111);
        bus.addr0 = 10'h013;
        bus.oe0   = 1'b1;
        bus.addr1 = 10'h010;
        bus.oe1   = 1'b1;
        tick();
        idle();
        check("full_word_p0", bus.rdata0, 32'hDEADBEEF);
        check("full_word_p1", bus.rdata1, 32'hDEADBEEF);

        // Reset in the middle of the clock phase clears rdata without an edge.
        #2 rst = 1'b0;
        #1;
        check("async_rst_p0", bus.rdata0, 32'h0);
        check("async_rst_p1", bus.rdata1, 32'h0);
        @(negedge clk);
        // This write and read happen while reset is held, so both are ignored.
        bus.addr0  = 10'h010;
        bus.wdata0 = 32'h00000000;
        bus.we0    = 4'b1111;
        bus.oe0    = 1'b1;
        tick();
        idle();
        check("rst_read_ignored", bus.rdata0, 32'h0);
        rst = 1'b1;
        rd0(10'h010);
        check("rst_write_dropped", bus.rdata0, 32'hDEADBEEF);

        // 3. Byte enables on port 1 over DEADBEEF
        bus.addr1  = 10'h010;
        bus.wdata1 = 32'h11223344;
        bus.we1    = 4'b0101;
        tick();
        idle();
        rd0(10'h010);
        check("byte_enable", bus.rdata0, 32'hDE22BE44);

        // 4a. Read-first with a same-port write
        wr0(10'h020, 32'hAAAAAAAA, 4'b1111);
        bus.addr0  = 10'h020;
        bus.wdata0 = 32'h55555555;
        bus.we0    = 4'b1111;
        bus.oe0    = 1'b1;
        tick();
        idle();
        check("read_first_p0_old", bus.rdata0, 32'hAAAAAAAA);
        rd0(10'h020);
        check("read_first_p0_new", bus.rdata0, 32'h55555555);

        // 4b. Read-first with a cross-port write from port 1
        wr0(10'h020, 32'hAAAAAAAA, 4'b1111);
        bus.addr0  = 10'h020;
        bus.oe0    = 1'b1;
        bus.addr1  = 10'h020;
        bus.wdata1 = 32'h55555555;
        bus.we1    = 4'b1111;
        tick();
        idle();
        check("read_first_p1_old", bus.rdata0, 32'hAAAAAAAA);
        rd0(10'h020);
        check("read_first_p1_new", bus.rdata0, 32'h55555555);

        // 5. Same-edge collision: port 1 owns bytes 1:0
        bus.addr0  = 10'h040;
        bus.wdata0 = 32'h01020304;
        bus.we0    = 4'b1111;
        bus.addr1  = 10'h040;
        bus.wdata1 = 32'hA0B0C0D0;
        bus.we1    = 4'b0011;
        tick();
        idle();
        bus.addr1 = 10'h040;
        bus.oe1   = 1'b1;
        tick();
        idle();
        check("collision", bus.rdata1, 32'h0102C0D0);

        // 6. Last word, hold, and word 0 untouched
        wr0(10'h3FC, 32'hCAFEF00D, 4'b1111);
        rd0(10'h3FC);
        check("last_word", bus.rdata0, 32'hCAFEF00D);
        bus.addr0 = 10'h000;
        tick();
        tick();
        check("hold_oe0_low", bus.rdata0, 32'hCAFEF00D);
        rd0(10'h000);
        check("word0_untouched", bus.rdata0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_dual_port_byte_ram
`default_nettype wire
